// File: rtl/adder_operand_loader.sv
// rtl/adder_operand_loader.sv - assembles streamed W-bit words into adder operands A/B/c0
// Optional parity checking is enabled by defining PARITY_CHECK_EN.
module adder_operand_loader #(
  parameter int W       = 32,
  parameter int MaxBit  = 128,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      in_word,
  input  logic              in_par,
  input  logic              in_cin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr_err,
  output logic [MaxBit-1:0] op_a,
  output logic [MaxBit-1:0] op_b,
  output logic              op_c0,
  output logic              op_strobe,
  output logic              res_valid,
  output logic              par_err
);

  localparam int N     = MaxBit / W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT, WAIT} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               xfer;
  logic               last;
  logic               word_bad;
  logic               pair_bad;

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign xfer      = in_valid && in_ready;
  assign last      = (idx == IDX_W'(N - 1));
  assign op_strobe = (state == PRESENT);
  assign res_valid = (state == WAIT) && (cnt == '0);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    case (state)
      LOAD_A: begin
        if (xfer) begin
          if (last) begin
            idx_nx   = '0;
            state_nx = LOAD_B;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          if (last) begin
            idx_nx   = '0;
            // A pair with any corrupted word is dropped without reaching the adder
            state_nx = (pair_bad || word_bad) ? LOAD_A : PRESENT;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
      end
      PRESENT: begin
        cnt_nx   = CNT_W'(ADD_LAT - 1);
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nx = LOAD_A;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      default: state_nx = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      idx   <= '0;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_c0 <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      if (xfer) begin
        for (int i = 0; i < N; i++) begin
          if (idx == IDX_W'(i)) begin
            if (state == LOAD_A) op_a[i*W +: W] <= in_word;
            else                 op_b[i*W +: W] <= in_word;
          end
        end
        if (state == LOAD_B && last) op_c0 <= in_cin;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  assign word_bad = ^{in_par, in_word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_bad <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      if (xfer) begin
        if (state == LOAD_B && last) pair_bad <= 1'b0;
        else if (word_bad)           pair_bad <= 1'b1;
      end
      if (clr_err)               par_err <= 1'b0;
      else if (xfer && word_bad) par_err <= 1'b1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = in_par ^ clr_err;
  assign word_bad      = 1'b0;
  assign pair_bad      = 1'b0;
  assign par_err       = 1'b0;
`endif

endmodule

// File: tb/tb_adder_operand_loader.sv
// tb/tb_adder_operand_loader.sv - directed bench with behavioural model for adder_operand_loader
module tb_adder_operand_loader;

  localparam int W  = 32;
  localparam int MB = 128;
  localparam int AL = 1;
  localparam int N  = MB / W;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_word = '0;
  logic          in_par = 1'b0;
  logic          in_cin = 1'b0;
  logic          in_valid = 1'b0;
  logic          clr_err = 1'b0;
  logic          in_ready;
  logic [MB-1:0] op_a, op_b;
  logic          op_c0, op_strobe, res_valid, par_err;

  adder_operand_loader #(.W(W), .MaxBit(MB), .ADD_LAT(AL)) dut (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_par(in_par), .in_cin(in_cin),
    .in_valid(in_valid), .in_ready(in_ready), .clr_err(clr_err), .op_a(op_a), .op_b(op_b),
    .op_c0(op_c0), .op_strobe(op_strobe), .res_valid(res_valid), .par_err(par_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobe_cyc = -1;
  int rv_cyc = -1;
  int strobe_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [MB-1:0] act, input logic [MB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: words fill A then B in order; after the last word the loader is busy for
  // 1 + AL cycles (strobe in the first, result-valid in the last), unless the pair was bad.
  logic [MB-1:0] m_a, m_b;
  logic          m_c0, m_perr, m_bad;
  int            m_cnt, m_hold;
  wire m_ready  = (m_hold == 0);
  wire m_strobe = (m_hold == AL + 1);
  wire m_rv     = (m_hold == 1);
  wire m_wbad   = PAR_EN && (^{in_par, in_word});

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_c0 <= 1'b0; m_perr <= 1'b0; m_bad <= 1'b0;
      m_cnt <= 0; m_hold <= 0;
    end else begin
      if (clr_err) m_perr <= 1'b0;
      else if (in_valid && m_ready && m_wbad) m_perr <= 1'b1;
      if (m_hold > 0) m_hold <= m_hold - 1;
      else if (in_valid) begin
        if (m_cnt < N) m_a[m_cnt*W +: W] <= in_word;
        else           m_b[(m_cnt-N)*W +: W] <= in_word;
        if (m_cnt == 2*N - 1) begin
          m_cnt  <= 0;
          m_c0   <= in_cin;
          m_bad  <= 1'b0;
          m_hold <= (m_bad || m_wbad) ? 0 : AL + 1;
        end else begin
          m_cnt <= m_cnt + 1;
          if (m_wbad) m_bad <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("op_a", op_a, m_a);
    check("op_b", op_b, m_b);
    check("op_c0", op_c0, m_c0);
    check("in_ready", in_ready, m_ready);
    check("op_strobe", op_strobe, m_strobe);
    check("res_valid", res_valid, m_rv);
    check("par_err", par_err, m_perr);
    if (op_strobe && res_valid) check("strobe_rv_overlap", 1, 0);
    if (op_strobe) begin
      strobe_cyc   <= cyc;
      strobe_total <= strobe_total + 1;
    end
    if (res_valid) rv_cyc <= cyc;
  end

  int last_xfer_cyc = 0;

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send(input logic [W-1:0] w, input logic bad_par, input logic cin, input int gap);
    bit done = 0;
    repeat (gap) begin in_valid = 1'b0; @(negedge clk); end
    in_word  = w;
    in_par   = (^w) ^ bad_par;
    in_cin   = cin;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (in_ready) done = 1;
      @(negedge clk);
    end
    last_xfer_cyc = cyc;
    if (!done) begin
      miscompares++;
      vectors++;
      $display("FAIL send_timeout: got no transfer expected transfer within 20 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pair(input logic [W-1:0] a0, input logic [W-1:0] b0, input int gap);
    for (int i = 0; i < N; i++) send(a0, 1'b0, 1'b0, gap);
    send(b0, 1'b0, 1'b0, gap);
    for (int i = 1; i < N; i++) send('0, 1'b0, 1'b0, gap);
  endtask

  logic [MB:0] sum;
  int k0, s0;

  initial begin
    // 1: reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_op_a", op_a, '0);
    check("rst_strobe", op_strobe, 0);
    check("rst_res_valid", res_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    idle(4);
    check("no_strobe_idle", strobe_total, 0);

    // 2: back-to-back A=all ones, B=1, cin=0
    k0 = cyc;
    for (int i = 0; i < N; i++) send(32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    send(32'h1, 1'b0, 1'b0, 0);
    for (int i = 1; i < N; i++) send(32'h0, 1'b0, 1'b0, 0);
    check("t2_op_a", op_a, {MB{1'b1}});
    check("t2_op_b", op_b, 128'h1);
    check("t2_op_c0", op_c0, 0);
    sum = {1'b0, m_a} + {1'b0, m_b} + {{MB{1'b0}}, m_c0};
    check("t2_sum", sum[MB-1:0], '0);
    check("t2_cout", sum[MB], 1);

    // 4: word held valid through PRESENT/WAIT lands in op_a[31:0]
    send(32'hA5A5_A5A5, 1'b0, 1'b0, 0);
    check("t2_strobe_cycle", strobe_cyc - k0, 8);
    check("t2_res_valid_cycle", rv_cyc - k0, 9);
    check("t4_op_a", op_a, {{(MB-W){1'b1}}, 32'hA5A5_A5A5});
    for (int i = 1; i < N; i++) send(32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    send(32'h1, 1'b0, 1'b1, 0);
    for (int i = 1; i < N; i++) send(32'h0, 1'b0, 1'b1, 0);
    check("t4_op_c0", op_c0, 1);
    idle(4);

    // 3: two idle cycles between every word
    send_pair(32'hFFFF_FFFF, 32'h1, 2);
    idle(1);
    check("t3_strobe_after_last", strobe_cyc, last_xfer_cyc);
    check("t3_op_a", op_a, {MB{1'b1}});
    check("t3_op_b", op_b, 128'h1);
    idle(3);

    // 5: reset after 5 transfers discards the partial pair
    for (int i = 0; i < 5; i++) send(32'h1234_0000 + i, 1'b0, 1'b0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_op_a", op_a, '0);
    check("t5_async_op_b", op_b, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s0 = strobe_total;
    for (int i = 0; i < 2*N; i++) send(32'h0100_0000 + i, 1'b0, 1'b0, 0);
    idle(4);
    check("t5_strobe_count", strobe_total - s0, 1);
    check("t5_op_a", op_a, {32'h0100_0003, 32'h0100_0002, 32'h0100_0001, 32'h0100_0000});
    check("t5_op_b", op_b, {32'h0100_0007, 32'h0100_0006, 32'h0100_0005, 32'h0100_0004});

`ifdef PARITY_CHECK_EN
    // 6: bad parity on third B word drops the pair; par_err sticky until clr_err
    s0 = strobe_total;
    for (int i = 0; i < N; i++) send(32'h0000_0011 + i, 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) send(32'h0000_0021 + i, (i == 2), 1'b0, 0);
    idle(4);
    check("t6_par_err", par_err, 1);
    check("t6_bad_no_strobe", strobe_total - s0, 0);
    send_pair(32'h0000_0003, 32'h0000_0005, 0);
    idle(4);
    check("t6_good_strobe", strobe_total - s0, 1);
    check("t6_par_err_sticky", par_err, 1);
    clr_err = 1'b1;
    send(32'h0000_0007, 1'b1, 1'b0, 0);
    clr_err = 1'b0;
    idle(1);
    check("t6_clr_wins", par_err, 0);
    for (int i = 1; i < 2*N; i++) send(32'h0, 1'b0, 1'b0, 0);
    idle(4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
